// File: rtl/ps2_key_event.sv
// PS/2 keyboard front end: sync + clock filter + 11-bit frame deserialiser + E0/F0 prefix collapse.
// Latency: key_valid/frame_err one cycle after the stop-bit strobe; no backpressure (strobes are fire-and-forget).
// Optional odd-parity enforcement under `define PS2_PARITY_CHECK_EN.
module ps2_key_event #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        kclk,
  input  logic        kdata,
  output logic        key_valid,
  output logic [7:0]  key_code,
  output logic        key_ext,
  output logic        key_break,
  output logic        frame_err,
  output logic [31:0] keycode_hist
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    FL_M1  = 8'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_M1 = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          kclk_s1, kclk_s2, kdata_s1, kdata_s2;
  logic          kclk_f, kclk_f_d;
  logic [7:0]    flt_cnt;
  logic          strobe;
  state_t        state, state_n;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit, accept, drop, parity_ok;
  logic          ext_pend, brk_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      kclk_s1  <= 1'b1;
      kclk_s2  <= 1'b1;
      kdata_s1 <= 1'b1;
      kdata_s2 <= 1'b1;
    end else begin
      kclk_s1  <= kclk;
      kclk_s2  <= kclk_s1;
      kdata_s1 <= kdata;
      kdata_s2 <= kdata_s1;
    end
  end

  // Level only moves after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      kclk_f   <= 1'b1;
      kclk_f_d <= 1'b1;
      flt_cnt  <= '0;
    end else begin
      kclk_f_d <= kclk_f;
      if (kclk_s2 == kclk_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FL_M1) begin
        kclk_f  <= kclk_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 8'd1;
      end
    end
  end

  assign strobe  = kclk_f_d & ~kclk_f;
  assign tmo_hit = (state != IDLE) && !strobe && (tmo_cnt == TMO_M1);

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;
  always_ff @(posedge clk) begin
    if (rst)                              par_bit <= 1'b0;
    else if (strobe && state == PARITY)   par_bit <= kdata_s2;
  end
  assign parity_ok = ^{shreg, par_bit};
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    drop    = 1'b0;
    if (tmo_hit) begin
      state_n = IDLE;
      drop    = 1'b1;
    end else if (strobe) begin
      case (state)
        IDLE:    if (!kdata_s2) state_n = DATA;
        DATA:    if (bit_cnt == 3'd7) state_n = PARITY;
        PARITY:  state_n = STOP;
        STOP: begin
          state_n = IDLE;
          if (kdata_s2 && parity_ok) accept = 1'b1;
          else                       drop   = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      tmo_cnt <= '0;
    end else begin
      state <= state_n;
      if (state != DATA || tmo_hit) begin
        bit_cnt <= '0;
      end else if (strobe) begin
        bit_cnt <= bit_cnt + 3'd1;
        shreg   <= {kdata_s2, shreg[7:1]};
      end
      if (state == IDLE || strobe || tmo_hit) tmo_cnt <= '0;
      else                                    tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid    <= 1'b0;
      key_code     <= '0;
      key_ext      <= 1'b0;
      key_break    <= 1'b0;
      frame_err    <= 1'b0;
      keycode_hist <= '0;
      ext_pend     <= 1'b0;
      brk_pend     <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      if (drop) begin
        frame_err <= 1'b1;
        ext_pend  <= 1'b0;
        brk_pend  <= 1'b0;
      end else if (accept) begin
        keycode_hist <= {keycode_hist[23:0], shreg};
        if (shreg == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk_pend <= 1'b1;
        end else begin
          key_valid <= 1'b1;
          key_code  <= shreg;
          key_ext   <= ext_pend;
          key_break <= brk_pend;
          ext_pend  <= 1'b0;
          brk_pend  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_event.sv
// Directed bench for ps2_key_event: make/break/extended events, parity, timeout, glitch, mid-frame reset.
module tb_ps2_key_event;
  localparam int FL  = 8;
  localparam int TMO = 500;
  localparam int H   = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        kclk = 1'b1;
  logic        kdata = 1'b1;
  logic        key_valid, key_ext, key_break, frame_err;
  logic [7:0]  key_code;
  logic [31:0] keycode_hist;

  int checks = 0;
  int errors = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  int v0, e0;

  ps2_key_event #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .kclk(kclk), .kdata(kdata),
    .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
    .key_break(key_break), .frame_err(frame_err), .keycode_hist(keycode_hist)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_valid) vld_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      kdata = bits[i];
      cyc(H);
      kclk = 1'b0;
      cyc(H);
      kclk = 1'b1;
    end
    kdata = 1'b1;
    cyc(H);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic flip);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ flip, b, 1'b0};
    send_bits(bits, 11);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2);
  endtask

  task automatic snap();
    v0 = vld_cnt;
    e0 = err_cnt;
  endtask

  initial begin
    do_reset();
    chk("rst_valid", {31'b0, key_valid}, 32'd0);
    chk("rst_code",  {24'b0, key_code}, 32'd0);
    chk("rst_ext",   {31'b0, key_ext}, 32'd0);
    chk("rst_brk",   {31'b0, key_break}, 32'd0);
    chk("rst_err",   {31'b0, frame_err}, 32'd0);
    chk("rst_hist",  keycode_hist, 32'd0);

    // Plain make code
    snap();
    send_byte(8'h1C, 1'b0);
    chk("mk_vld_cnt", vld_cnt - v0, 32'd1);
    chk("mk_err_cnt", err_cnt - e0, 32'd0);
    chk("mk_code", {24'b0, key_code}, 32'h1C);
    chk("mk_ext",  {31'b0, key_ext}, 32'd0);
    chk("mk_brk",  {31'b0, key_break}, 32'd0);
    chk("mk_hist", keycode_hist, 32'h0000001C);

    // Break: F0 prefix produces no event of its own
    snap();
    send_byte(8'hF0, 1'b0);
    chk("f0_no_vld", vld_cnt - v0, 32'd0);
    chk("f0_hist", keycode_hist, 32'h00001CF0);
    send_byte(8'h1C, 1'b0);
    chk("brk_vld_cnt", vld_cnt - v0, 32'd1);
    chk("brk_code", {24'b0, key_code}, 32'h1C);
    chk("brk_brk",  {31'b0, key_break}, 32'd1);
    chk("brk_ext",  {31'b0, key_ext}, 32'd0);
    chk("brk_hist", keycode_hist, 32'h001CF01C);

    // Extended break
    do_reset();
    snap();
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    chk("ext_vld_cnt", vld_cnt - v0, 32'd1);
    chk("ext_code", {24'b0, key_code}, 32'h75);
    chk("ext_ext",  {31'b0, key_ext}, 32'd1);
    chk("ext_brk",  {31'b0, key_break}, 32'd1);
    chk("ext_hist", keycode_hist, 32'h00E0F075);

    // Wrong parity bit
    do_reset();
    snap();
    send_byte(8'h1C, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    chk("par_err_cnt", err_cnt - e0, 32'd1);
    chk("par_vld_cnt", vld_cnt - v0, 32'd0);
    chk("par_hist", keycode_hist, 32'd0);
`else
    chk("par_err_cnt", err_cnt - e0, 32'd0);
    chk("par_vld_cnt", vld_cnt - v0, 32'd1);
    chk("par_code", {24'b0, key_code}, 32'h1C);
`endif

    // Timeout mid-frame; the pending E0 must be dropped with it
    do_reset();
    send_byte(8'hE0, 1'b0);
    snap();
    send_bits(11'b000_0010_1010, 6);
    chk("tmo_early", err_cnt - e0, 32'd0);
    cyc(TMO + 100);
    chk("tmo_err_cnt", err_cnt - e0, 32'd1);
    send_byte(8'h29, 1'b0);
    chk("tmo_vld_cnt", vld_cnt - v0, 32'd1);
    chk("tmo_code", {24'b0, key_code}, 32'h29);
    chk("tmo_ext",  {31'b0, key_ext}, 32'd0);
    chk("tmo_err_once", err_cnt - e0, 32'd1);
    chk("tmo_hist", keycode_hist, 32'h0000E029);

    // Short clock glitch with data low must not look like a start bit
    snap();
    kdata = 1'b0;
    cyc(5);
    kclk = 1'b0;
    cyc(4);
    kclk = 1'b1;
    cyc(5);
    kdata = 1'b1;
    cyc(40);
    send_byte(8'h1C, 1'b0);
    chk("gl_vld_cnt", vld_cnt - v0, 32'd1);
    chk("gl_err_cnt", err_cnt - e0, 32'd0);
    chk("gl_code", {24'b0, key_code}, 32'h1C);

    // Reset in the middle of a frame
    snap();
    send_bits(11'b000_0000_1010, 4);
    rst = 1'b1;
    cyc(3);
    chk("mr_valid", {31'b0, key_valid}, 32'd0);
    chk("mr_code", {24'b0, key_code}, 32'd0);
    chk("mr_hist", keycode_hist, 32'd0);
    rst = 1'b0;
    cyc(2 * TMO);
    chk("mr_no_err", err_cnt - e0, 32'd0);
    send_byte(8'h1C, 1'b0);
    chk("mr_vld_cnt", vld_cnt - v0, 32'd1);
    chk("mr_code2", {24'b0, key_code}, 32'h1C);
    chk("mr_hist2", keycode_hist, 32'h0000001C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
